// File: rtl/pwm_deadtime_gen_if.sv
// pwm_deadtime_gen_if
// Bus bundle between the MPPT duty-cycle controller side (master) and the
// complementary gate-drive generator (slave). Clock and reset are not part of
// the bundle; they stay plain ports on the generator.
interface pwm_deadtime_gen_if;
    logic       i_en;            // run request
    logic [7:0] i_duty_in;       // duty command, 0-255 carrier steps
    logic       i_duty_valid;    // one-cycle strobe, captures i_duty_in into shadow
    logic       i_fault_in;      // level-sensitive overcurrent/overvoltage fault
    logic       i_fault_clr;     // clears a latched fault once i_fault_in is low
    logic       o_hs_out;        // high-side gate drive
    logic       o_ls_out;        // low-side gate drive
    logic       o_period_start;  // one-cycle pulse at the start of each carrier period
    logic [7:0] o_duty_applied;  // clamped duty currently in effect
    logic       o_fault_active;  // fault latched

    modport master (
        output i_en, i_duty_in, i_duty_valid, i_fault_in, i_fault_clr,
        input  o_hs_out, o_ls_out, o_period_start, o_duty_applied, o_fault_active
    );

    modport slave (
        input  i_en, i_duty_in, i_duty_valid, i_fault_in, i_fault_clr,
        output o_hs_out, o_ls_out, o_period_start, o_duty_applied, o_fault_active
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen
// Complementary high-side/low-side PWM generator for the DC-DC power stage.
// A fixed 256-step carrier (advanced every PRESCALE clocks) is compared with a
// clamped duty value that is reloaded from a shadow register only at period
// boundaries. Dead time is inserted before every gate rising edge, and a
// latched fault forces both gates low until explicitly cleared.
//
// Optional build macro PWM_SOFT_START_EN: when defined, every RUN entry from
// IDLE starts at DUTY_MIN and the applied duty then slews by at most one step
// per period toward the clamped shadow value. When undefined, the applied duty
// jumps straight to the clamped shadow value at each load.
module pwm_deadtime_gen #(
    parameter int DEADTIME = 4,    // dead time in clk cycles before each gate rising edge
    parameter int DUTY_MIN = 8,    // lower duty clamp, must exceed DEADTIME
    parameter int DUTY_MAX = 240,  // upper duty clamp, 256-DUTY_MAX must exceed DEADTIME
    parameter int PRESCALE = 1     // clk cycles per carrier step, 1 or more
) (
    input  logic              clk,
    input  logic              rst,
    pwm_deadtime_gen_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [7:0]  C_DT         = 8'(DEADTIME);
    localparam logic [7:0]  C_DUTY_MIN   = 8'(DUTY_MIN);
    localparam logic [7:0]  C_DUTY_MAX   = 8'(DUTY_MAX);
    localparam logic [7:0]  C_SHADOW_RST = 8'd128;
    localparam logic [7:0]  C_CNT_LAST   = 8'hFF;
    localparam logic [15:0] C_PRE_LAST   = 16'(PRESCALE - 1);

    // Limit a duty command to the range that keeps both gate edges in every period.
    function automatic logic [7:0] clamp_duty(input logic [7:0] duty);
        logic [7:0] result;
        if (duty < C_DUTY_MIN) begin
            result = C_DUTY_MIN;
        end else if (duty > C_DUTY_MAX) begin
            result = C_DUTY_MAX;
        end else begin
            result = duty;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;          // carrier count
    logic [15:0] r_pre;          // clk cycles spent on the current carrier step
    logic [7:0]  r_shadow;       // latest duty command, not yet in effect
    logic [7:0]  r_duty;         // clamped duty in effect for the current period
    logic        r_raw_q;        // raw PWM from the previous cycle, for edge detection
    logic [7:0]  r_dt;           // cycles since the last raw transition, saturating
    logic        r_hs;
    logic        r_ls;
    logic        r_period_start;
    logic        r_fault_active;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic       w_run;
    logic       w_start;         // IDLE -> RUN this cycle
    logic       w_step;          // carrier advances at the end of this cycle
    logic       w_wrap;          // carrier goes 255 -> 0 at the end of this cycle
    logic       w_reload;        // period boundary that continues running
    logic       w_raw;
    logic       w_gate_ok;       // dead time elapsed and no fault pending
    logic [7:0] w_target;
    logic [7:0] w_duty_entry;
    logic [7:0] w_duty_next;
    logic [7:0] w_dt_next;

    assign w_run     = (r_state == ST_RUN);
    // Fault has priority over en, so a pending fault blocks RUN entry.
    assign w_start   = (r_state == ST_IDLE) && bus.i_en && !bus.i_fault_in;
    assign w_step    = w_run && (r_pre == C_PRE_LAST);
    assign w_wrap    = w_step && (r_cnt == C_CNT_LAST);
    assign w_reload  = w_wrap && bus.i_en && !bus.i_fault_in;
    assign w_target  = clamp_duty(r_shadow);
    assign w_raw     = w_run && (r_cnt < r_duty);
    assign w_gate_ok = (w_dt_next == C_DT) && !bus.i_fault_in;

    // Choose the duty loaded on RUN entry and at each continuing period boundary.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_duty_entry = w_target;
        w_duty_next  = w_target;
`ifdef PWM_SOFT_START_EN
        w_duty_entry = C_DUTY_MIN;
        if (w_target > r_duty) begin
            w_duty_next = r_duty + 8'd1;
        end else if (w_target < r_duty) begin
            w_duty_next = r_duty - 8'd1;
        end else begin
            w_duty_next = r_duty;
        end
`endif
    end

    // Dead-time counter next value: restart on any raw edge, otherwise count up and hold.
    always_comb begin
        w_dt_next = r_dt;
        if (w_raw != r_raw_q) begin
            w_dt_next = 8'd0;
        end else if (r_dt < C_DT) begin
            w_dt_next = r_dt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Operating-mode FSM: IDLE -> RUN on request, RUN -> FAULT on fault, RUN -> IDLE at a boundary with en low.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every always_ff samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.i_fault_in) begin
                        r_state <= ST_FAULT;
                    end else if (w_wrap && !bus.i_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (bus.i_fault_clr && !bus.i_fault_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Carrier and prescaler: run only in RUN, held at zero otherwise or when a fault trips.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_pre <= 16'd0;
        end else if (!w_run || bus.i_fault_in) begin
            r_cnt <= 8'd0;
            r_pre <= 16'd0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 8'd1;
            r_pre <= 16'd0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // Shadow register: capture every duty strobe regardless of mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= C_SHADOW_RST;
        end else if (bus.i_duty_valid) begin
            r_shadow <= bus.i_duty_in;
        end
    end

    // Applied duty: loaded only on RUN entry and at continuing period boundaries, so a period never changes mid-way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= C_DUTY_MIN;
        end else if (w_start) begin
            r_duty <= w_duty_entry;
        end else if (w_reload) begin
            r_duty <= w_duty_next;
        end
    end

    // Period-start pulse: marks the first cycle of each carrier period at count 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_start || w_reload;
        end
    end

    // Dead-time tracking: remember raw and the cycles elapsed since it last changed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw_q <= 1'b0;
            r_dt    <= 8'd0;
        end else begin
            r_raw_q <= w_raw;
            r_dt    <= w_dt_next;
        end
    end

    // Gate drivers: registered, only after the dead time, and dropped on the edge after a fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs <= 1'b0;
            r_ls <= 1'b0;
        end else begin
            r_hs <= w_raw && w_gate_ok;
            r_ls <= !w_raw && w_run && w_gate_ok;
        end
    end

    // Fault latch: set when a fault trips RUN, cleared only by fault_clr with the fault gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_active <= 1'b0;
        end else if (w_run && bus.i_fault_in) begin
            r_fault_active <= 1'b1;
        end else if ((r_state == ST_FAULT) && bus.i_fault_clr && !bus.i_fault_in) begin
            r_fault_active <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_hs_out       = r_hs;
    assign bus.o_ls_out       = r_ls;
    assign bus.o_period_start = r_period_start;
    assign bus.o_duty_applied = r_duty;
    assign bus.o_fault_active = r_fault_active;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen
// Directed bench for pwm_deadtime_gen with DEADTIME=4, PRESCALE=1,
// DUTY_MIN=8, DUTY_MAX=240. Inputs are driven and outputs sampled on the
// falling clock edge; every expected value below is hand-computed.
module tb_pwm_deadtime_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_deadtime_gen_if u_if ();

    pwm_deadtime_gen #(
        .DEADTIME (4),
        .DUTY_MIN (8),
        .DUTY_MAX (240),
        .PRESCALE (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Step to the next falling edge until period_start is seen or the budget runs out.
    task automatic wait_pstart(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            u_if.i_duty_valid = 1'b0;
            if (u_if.o_period_start === 1'b1) found = 1'b1;
        end
    endtask

    // Observe one full period starting on a period_start cycle, with optional strobe and en drop.
    task automatic run_period(input int strobe_at, input logic [7:0] strobe_val, input int en_drop_at,
                              output int hs_n, output int ls_n, output int low_n, output int both_n,
                              output int extra_ps, output logic end_ps);
        hs_n = 0; ls_n = 0; low_n = 0; both_n = 0; extra_ps = 0;
        for (int i = 0; i < 256; i++) begin
            if (u_if.o_hs_out === 1'b1) hs_n++;
            if (u_if.o_ls_out === 1'b1) ls_n++;
            if (u_if.o_hs_out === 1'b0 && u_if.o_ls_out === 1'b0) low_n++;
            if (u_if.o_hs_out === 1'b1 && u_if.o_ls_out === 1'b1) both_n++;
            if (i > 0 && u_if.o_period_start === 1'b1) extra_ps++;
            u_if.i_duty_valid = 1'b0;
            if (i == strobe_at) begin
                u_if.i_duty_in    = strobe_val;
                u_if.i_duty_valid = 1'b1;
            end
            if (i == en_drop_at) u_if.i_en = 1'b0;
            @(negedge clk);
        end
        u_if.i_duty_valid = 1'b0;
        end_ps = u_if.o_period_start;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.i_en = 1'b0; u_if.i_duty_in = 8'd0; u_if.i_duty_valid = 1'b0;
        u_if.i_fault_in = 1'b0; u_if.i_fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (u_if.o_hs_out !== 1'b0) begin n_fail++; $display("FAIL reset_hs: got %b expected 0", u_if.o_hs_out); end
        n_tests++; if (u_if.o_ls_out !== 1'b0) begin n_fail++; $display("FAIL reset_ls: got %b expected 0", u_if.o_ls_out); end
        n_tests++; if (u_if.o_period_start !== 1'b0) begin n_fail++; $display("FAIL reset_pstart: got %b expected 0", u_if.o_period_start); end
        n_tests++; if (u_if.o_fault_active !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", u_if.o_fault_active); end
        n_tests++; if (u_if.o_duty_applied !== 8'd8) begin n_fail++; $display("FAIL reset_duty: got %0d expected 8", u_if.o_duty_applied); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_steady_128();
        logic found, end_ps;
        int hs_n, ls_n, low_n, both_n, extra;
        u_if.i_duty_in = 8'd128; u_if.i_duty_valid = 1'b1; u_if.i_en = 1'b1;
        wait_pstart(4, found);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t1_first_pstart: got %b expected 1", found); end
        n_tests++; if (u_if.o_duty_applied !== 8'd128) begin n_fail++; $display("FAIL t1_duty: got %0d expected 128", u_if.o_duty_applied); end
        run_period(-1, 8'd0, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (end_ps !== 1'b1) begin n_fail++; $display("FAIL t1_period_len: got %b expected 1", end_ps); end
        run_period(-1, 8'd0, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 124) begin n_fail++; $display("FAIL t1_hs_high: got %0d expected 124", hs_n); end
        n_tests++; if (ls_n !== 124) begin n_fail++; $display("FAIL t1_ls_high: got %0d expected 124", ls_n); end
        n_tests++; if (low_n !== 8) begin n_fail++; $display("FAIL t1_both_low: got %0d expected 8", low_n); end
        n_tests++; if (both_n !== 0) begin n_fail++; $display("FAIL t1_overlap: got %0d expected 0", both_n); end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL t1_extra_pstart: got %0d expected 0", extra); end
        n_tests++; if (end_ps !== 1'b1) begin n_fail++; $display("FAIL t1_next_pstart: got %b expected 1", end_ps); end
    endtask

    task automatic test_duty_clamp();
        logic end_ps;
        int hs_n, ls_n, low_n, both_n, extra;
        run_period(10, 8'd250, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 124) begin n_fail++; $display("FAIL t2_hs_before_load: got %0d expected 124", hs_n); end
        n_tests++; if (u_if.o_duty_applied !== 8'd240) begin n_fail++; $display("FAIL t2_clamp_high: got %0d expected 240", u_if.o_duty_applied); end
        run_period(10, 8'd2, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 236) begin n_fail++; $display("FAIL t2_hs_240: got %0d expected 236", hs_n); end
        n_tests++; if (ls_n !== 12) begin n_fail++; $display("FAIL t2_ls_240: got %0d expected 12", ls_n); end
        n_tests++; if (both_n !== 0) begin n_fail++; $display("FAIL t2_overlap_240: got %0d expected 0", both_n); end
        n_tests++; if (u_if.o_duty_applied !== 8'd8) begin n_fail++; $display("FAIL t2_clamp_low: got %0d expected 8", u_if.o_duty_applied); end
        run_period(10, 8'd128, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 4) begin n_fail++; $display("FAIL t2_hs_8: got %0d expected 4", hs_n); end
        n_tests++; if (ls_n !== 244) begin n_fail++; $display("FAIL t2_ls_8: got %0d expected 244", ls_n); end
    endtask

    task automatic test_shadow_timing();
        logic end_ps;
        int hs_n, ls_n, low_n, both_n, extra;
        n_tests++; if (u_if.o_duty_applied !== 8'd128) begin n_fail++; $display("FAIL t3_duty_128: got %0d expected 128", u_if.o_duty_applied); end
        run_period(100, 8'd64, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 124) begin n_fail++; $display("FAIL t3_hs_keeps_128: got %0d expected 124", hs_n); end
        n_tests++; if (u_if.o_duty_applied !== 8'd64) begin n_fail++; $display("FAIL t3_duty_64: got %0d expected 64", u_if.o_duty_applied); end
        run_period(-1, 8'd0, -1, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 60) begin n_fail++; $display("FAIL t3_hs_64: got %0d expected 60", hs_n); end
        n_tests++; if (ls_n !== 188) begin n_fail++; $display("FAIL t3_ls_64: got %0d expected 188", ls_n); end
    endtask

    task automatic test_fault();
        repeat (50) @(negedge clk);
        n_tests++; if (u_if.o_hs_out !== 1'b1) begin n_fail++; $display("FAIL t4_hs_before_fault: got %b expected 1", u_if.o_hs_out); end
        u_if.i_fault_in = 1'b1;
        @(negedge clk);
        n_tests++; if (u_if.o_hs_out !== 1'b0) begin n_fail++; $display("FAIL t4_hs_cut: got %b expected 0", u_if.o_hs_out); end
        n_tests++; if (u_if.o_ls_out !== 1'b0) begin n_fail++; $display("FAIL t4_ls_cut: got %b expected 0", u_if.o_ls_out); end
        n_tests++; if (u_if.o_fault_active !== 1'b1) begin n_fail++; $display("FAIL t4_fault_set: got %b expected 1", u_if.o_fault_active); end
        u_if.i_fault_clr = 1'b1;
        @(negedge clk);
        u_if.i_fault_clr = 1'b0;
        @(negedge clk);
        u_if.i_fault_in = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (u_if.o_fault_active !== 1'b1) begin n_fail++; $display("FAIL t4_fault_latched: got %b expected 1", u_if.o_fault_active); end
        n_tests++; if (u_if.o_hs_out !== 1'b0 || u_if.o_ls_out !== 1'b0) begin n_fail++; $display("FAIL t4_gates_low: got hs=%b ls=%b expected 0 0", u_if.o_hs_out, u_if.o_ls_out); end
        u_if.i_fault_clr = 1'b1;
        @(negedge clk);
        u_if.i_fault_clr = 1'b0;
        n_tests++; if (u_if.o_fault_active !== 1'b0) begin n_fail++; $display("FAIL t4_fault_cleared: got %b expected 0", u_if.o_fault_active); end
        n_tests++; if (u_if.o_period_start !== 1'b0) begin n_fail++; $display("FAIL t4_idle_no_pstart: got %b expected 0", u_if.o_period_start); end
        @(negedge clk);
        n_tests++; if (u_if.o_period_start !== 1'b1) begin n_fail++; $display("FAIL t4_restart_pstart: got %b expected 1", u_if.o_period_start); end
        n_tests++; if (u_if.o_duty_applied !== 8'd64) begin n_fail++; $display("FAIL t4_restart_duty: got %0d expected 64", u_if.o_duty_applied); end
    endtask

    task automatic test_stop();
        logic end_ps;
        int hs_n, ls_n, low_n, both_n, extra, active;
        run_period(-1, 8'd0, 30, hs_n, ls_n, low_n, both_n, extra, end_ps);
        n_tests++; if (hs_n !== 60) begin n_fail++; $display("FAIL t5_hs_after_en_drop: got %0d expected 60", hs_n); end
        n_tests++; if (ls_n !== 187) begin n_fail++; $display("FAIL t5_ls_entry_period: got %0d expected 187", ls_n); end
        n_tests++; if (end_ps !== 1'b0) begin n_fail++; $display("FAIL t5_no_reload: got %b expected 0", end_ps); end
        repeat (2) @(negedge clk);
        active = 0;
        for (int i = 0; i < 300; i++) begin
            if (u_if.o_hs_out !== 1'b0 || u_if.o_ls_out !== 1'b0 || u_if.o_period_start !== 1'b0) active++;
            @(negedge clk);
        end
        n_tests++; if (active !== 0) begin n_fail++; $display("FAIL t5_idle_quiet: got %0d active cycles expected 0", active); end
    endtask

    task automatic test_reset_mid_run();
        logic found;
        u_if.i_en = 1'b1;
        wait_pstart(4, found);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_run_pstart: got %b expected 1", found); end
        repeat (100) @(negedge clk);
        n_tests++; if (u_if.o_ls_out !== 1'b1) begin n_fail++; $display("FAIL rst_ls_before: got %b expected 1", u_if.o_ls_out); end
        rst = 1'b1;
        u_if.i_en = 1'b0;
        @(negedge clk);
        n_tests++; if (u_if.o_hs_out !== 1'b0 || u_if.o_ls_out !== 1'b0) begin n_fail++; $display("FAIL rst_gates: got hs=%b ls=%b expected 0 0", u_if.o_hs_out, u_if.o_ls_out); end
        n_tests++; if (u_if.o_period_start !== 1'b0) begin n_fail++; $display("FAIL rst_pstart: got %b expected 0", u_if.o_period_start); end
        n_tests++; if (u_if.o_fault_active !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", u_if.o_fault_active); end
        n_tests++; if (u_if.o_duty_applied !== 8'd8) begin n_fail++; $display("FAIL rst_duty: got %0d expected 8", u_if.o_duty_applied); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_soft_start();
        logic found;
        int exp_duty;
        u_if.i_en = 1'b1;
        wait_pstart(4, found);
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t6_first_pstart: got %b expected 1", found); end
`ifdef PWM_SOFT_START_EN
        exp_duty = 8;
`else
        exp_duty = 128;
`endif
        n_tests++; if (u_if.o_duty_applied !== 8'(exp_duty)) begin n_fail++; $display("FAIL t6_duty_k0: got %0d expected %0d", u_if.o_duty_applied, exp_duty); end
        for (int k = 1; k <= 121; k++) begin
            wait_pstart(300, found);
            n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL t6_pstart_k%0d: got %b expected 1", k, found); end
`ifdef PWM_SOFT_START_EN
            exp_duty = (8 + k > 128) ? 128 : 8 + k;
`else
            exp_duty = 128;
`endif
            n_tests++; if (u_if.o_duty_applied !== 8'(exp_duty)) begin n_fail++; $display("FAIL t6_duty_k%0d: got %0d expected %0d", k, u_if.o_duty_applied, exp_duty); end
        end
    endtask

    initial begin
        test_reset();
`ifndef PWM_SOFT_START_EN
        test_steady_128();
        test_duty_clamp();
        test_shadow_timing();
        test_fault();
        test_stop();
`endif
        test_reset_mid_run();
        test_soft_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the MPPT duty-cycle controller.
- Converts the 8-bit duty command into a complementary high-side/low-side gate-drive pair for the DC-DC power stage.
- Uses a fixed 256-step carrier and shadow-registered duty updates at period boundaries.
- Adds duty clamping, programmable dead time, enable sequencing and a latched fault shutdown.

Parameters:
- DEADTIME, 4: dead-time length in clk cycles, inserted before each gate rising edge.
- DUTY_MIN, 8: lower duty clamp, in carrier steps. Must be greater than DEADTIME.
- DUTY_MAX, 240: upper duty clamp, in carrier steps. Must satisfy 256-DUTY_MAX > DEADTIME.
- PRESCALE, 1: clk cycles per carrier step. Must be 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run request
- duty_in  in  8  duty command (0-255), from the MPPT controller
- duty_valid  in  1  one-cycle strobe; captures duty_in into the shadow register
- fault_in  in  1  overcurrent/overvoltage fault, level-sensitive
- fault_clr  in  1  clears a latched fault
- hs_out  out  1  high-side gate drive
- ls_out  out  1  low-side gate drive
- period_start  out  1  one-cycle pulse when the carrier count is 0 on a step
- duty_applied  out  8  clamped duty currently in effect
- fault_active  out  1  fault latched

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: hs_out=0, ls_out=0, period_start=0, fault_active=0, duty_applied=DUTY_MIN, shadow=128, cnt=0, state=IDLE.
- Reset asserted mid-operation forces these values at the next edge, regardless of state.
- Carrier: 8-bit cnt.
  - Advances by 1 once every PRESCALE clk cycles while in RUN.
  - Wraps 255 -> 0.
- Shadow register: duty_valid=1 loads duty_in into shadow in any state.
- Load rule: at each period boundary (cnt==0 step) and on RUN entry, duty_applied <= clamp(shadow, DUTY_MIN, DUTY_MAX).
- Same-cycle update: a duty_valid coinciding with a load takes effect at the following boundary.
- Raw PWM: raw = (state==RUN) && (cnt < duty_applied).
- Dead time:
  - dt_cnt resets to 0 on every raw transition.
  - It increments each clk and saturates at DEADTIME.
  - hs_out <= raw && dt_cnt==DEADTIME.
  - ls_out <= !raw && dt_cnt==DEADTIME && state==RUN.
  - Outputs are registered, giving a 1-cycle latency from raw.
  - hs_out and ls_out are never both 1.
- FSM:
  - IDLE:
    - Outputs are low and cnt is held at 0.
    - en=1 and fault_in=0 -> RUN. The first step has cnt=0, period_start pulses, and duty is loaded.
  - RUN:
    - fault_in=1 -> FAULT immediately. hs_out and ls_out are 0 on the next edge, and fault_active=1.
    - en=0 -> the current period completes. At the next boundary the FSM goes to IDLE instead of reloading.
    - en re-asserted before that boundary cancels the stop.
  - FAULT:
    - Outputs are low and cnt is held at 0.
    - fault_clr=1 and fault_in=0 -> IDLE, with fault_active=0.
    - fault_clr is ignored while fault_in=1.
- Priority: rst > fault_in > en.
- Clamping prevents 0%/100% duty, so every period has both edges.
- Period: 256*PRESCALE clk cycles.
- High-side on-time: duty_applied*PRESCALE - DEADTIME cycles.

Optional Feature:
- Macro PWM_SOFT_START_EN.
- With the macro:
  - On each RUN entry from IDLE, duty_applied starts at DUTY_MIN.
  - At each boundary it moves by at most 1 step toward clamp(shadow), up or down.
  - This limits inrush after enable or fault recovery.
- Without the macro: duty_applied jumps directly to clamp(shadow) at each boundary.

Test Plan (DEADTIME=4, PRESCALE=1, DUTY_MIN=8, DUTY_MAX=240):
1. rst, then en=1, duty_in=128 strobed -> period_start every 256 clk; duty_applied=128. Per period: hs_out high 124 cycles, ls_out high 124 cycles, two 4-cycle both-low gaps. hs_out&ls_out never 1.
2. duty_in=250, then duty_in=2 -> duty_applied=240 after the next boundary, then 8. hs_out high 236 and 4 cycles respectively.
3. duty_in=64 strobed at cnt=100 with applied=128 -> current period keeps a 128-step high phase; next period hs_out high 60 cycles.
4. fault_in pulsed 3 cycles at cnt=50 -> hs_out/ls_out 0 on the next edge and fault_active=1, remaining after fault_in drops. fault_clr with en=1 -> IDLE then RUN, cnt=0, period_start pulse.
5. en dropped at cnt=30 -> switching continues to cnt=255, then IDLE with both outputs 0. rst asserted during RUN -> all reset values next edge.
6. With PWM_SOFT_START_EN, shadow=128, en=1 -> duty_applied 8,9,10... per period, reaching 128 after 120 boundaries. Without the macro -> 128 in the first period.
